segment_arbiter: RTL and testbench
==================================

// Module: segment_arbiter
// PURPOSE
//   Shares the single 8-digit 7-segment display between NREQ requesters
//   (e.g. free-running counter, CPU debug bus, fault codes).
//   Round-robin grant with a minimum dwell time, so each value stays readable.
//   Drives the 32-bit value input of segment_displayer.
//   Sits between the value sources and segment_displayer in top.
// PARAMETERS
//   NREQ        4   number of requesters (2..8)
//   WIDTH       32  value width; must equal the displayer value width
//   DWELL_LOG2  24  dwell period = 2**DWELL_LOG2 clk cycles
// PORTS
//   clk          in   1             system clock (BUFG output)
//   rst          in   1             synchronous reset, active-high
//   req          in   NREQ          req[i]=1: requester i wants the display
//   req_value    in   NREQ*WIDTH    value of requester i at [(i+1)*WIDTH-1:i*WIDTH]
//   grant        out  NREQ          one-hot grant, all-zero when idle
//   active_id    out  clog2(NREQ)   index of the granted requester
//   value_out    out  WIDTH         value to display (registered)
//   value_valid  out  1             1 while any requester is granted
// BEHAVIOUR
//   Reset: grant=0, active_id=0, value_out=0, value_valid=0, state IDLE,
//     dwell counter=0, round-robin pointer=0. Reset applies mid-dwell.
//   States: IDLE (no grant) and SHOW (one requester granted).
//   IDLE: any req bit seen at edge t grants the first set bit at or after the
//     RR pointer (wrapping NREQ-1 -> 0). From edge t: grant, active_id,
//     value_valid=1, dwell=0, state SHOW. All in one cycle.
//   SHOW: dwell counter increments by 1 each cycle. It is DWELL_LOG2 bits wide.
//     Expiry is the cycle where the counter is all-ones.
//   At expiry:
//     - another req bit is set: grant moves to the next set bit after
//       active_id (round-robin). RR pointer becomes new id + 1 (mod NREQ).
//       Counter wraps to 0.
//     - no other req bit is set: the current grant is kept and the counter
//       wraps to 0 (new dwell).
//   Granted requester drops req before expiry: at the next edge, rearbitrate
//     as if from IDLE, starting after the old id. No set bits: go to IDLE,
//     grant=0, value_valid=0, value_out holds its last value.
//   value_out <= slice of req_value for the grant being driven on the same
//     edge. A live value therefore tracks the source with 1-cycle latency.
//   Only one grant change per edge. A new request never shortens the
//     current dwell, except with SEGARB_PREEMPT_EN (below).
//   Simultaneous requests from IDLE: the lowest index at or after the RR
//     pointer wins.
//   req bits with no grant are not latched. A requester must hold req
//     until it sees grant.
// CONFIGURATION
//   SEGARB_PREEMPT_EN defined: requester 0 is a priority source (fault
//     display). req[0]=1 while another id is granted forces grant to 0 at the
//     next edge, regardless of dwell. The counter is reset to 0.
//   While id 0 is granted, ordinary dwell/round-robin rules apply.
//   SEGARB_PREEMPT_EN undefined: requester 0 is an ordinary round-robin
//     participant. No port or parameter differences between the two builds.
// TESTING  (bench uses NREQ=4, DWELL_LOG2=3, so dwell = 8 cycles)
//   1. Assert rst 3 cycles with req=4'b1111 -> grant=0, value_out=0,
//      value_valid=0 throughout. After release: grant=4'b0001 at 1st edge.
//   2. req=4'b0110, values 0xAAAA0001 (id1) / 0xBBBB0002 (id2) -> id1 shown
//      for 8 cycles, then id2 for 8, then id1. value_out changes on the
//      same edge as grant.
//   3. Only req[3]=1 for 30 cycles -> grant stays 4'b1000, no glitch at
//      dwell wrap. Drop req[3] -> IDLE next edge, value_out holds.
//   4. id1 granted, 3 cycles into dwell; drop req[1] with req[2]=1 ->
//      grant=4'b0100 on the next edge, dwell counter restarts at 0.
//   5. Change req_value of the granted id each cycle (counter source) ->
//      value_out equals the previous cycle's input every cycle.
//   6. PREEMPT build: id2 granted, 2 cycles into dwell; raise req[0] ->
//      grant=4'b0001 next edge. Non-PREEMPT build: id2 keeps its grant
//      for all 8 cycles.

Source files
------------

// File: rtl/segment_arbiter.sv
// rtl/segment_arbiter.sv - round-robin display arbiter with minimum dwell per grant
// Optional build macro: SEGARB_PREEMPT_EN (requester 0 preempts any other grant)
module segment_arbiter #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 32,
    parameter int DWELL_LOG2 = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      req_value,
    output logic [NREQ-1:0]            grant,
    output logic [$clog2(NREQ)-1:0]    active_id,
    output logic [WIDTH-1:0]           value_out,
    output logic                       value_valid
);
    localparam int IDW = $clog2(NREQ);
`ifdef SEGARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    typedef enum logic {IDLE, SHOW} state_t;

    state_t                state_q, state_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [IDW-1:0]        rr_q, rr_d;
    logic [DWELL_LOG2-1:0] dwell_q, dwell_d;
    logic [WIDTH-1:0]      value_q, value_d;
    logic [IDW:0]          pick_idle, pick_drop, pick_exp;

    function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ-1)) ? '0 : id + 1'b1;
    endfunction

    // Returns {found, id}: lowest wrapped offset from start with req set.
    // skip_last drops the final offset, i.e. the id just before start.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0] start,
                                             input logic skip_last);
        logic [IDW:0]   res;
        logic [IDW:0]   s;
        logic [IDW-1:0] idx;
        res = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            s = {1'b0, start} + (IDW+1)'(k);
            if (s >= (IDW+1)'(NREQ))
                s = s - (IDW+1)'(NREQ);
            idx = s[IDW-1:0];
            if (r[idx] && !(skip_last && k == NREQ-1))
                res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            rr_q    <= '0;
            dwell_q <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            dwell_q <= dwell_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        rr_d      = rr_q;
        dwell_d   = dwell_q + 1'b1;
        value_d   = value_q;
        pick_idle = rr_pick(req, rr_q, 1'b0);
        pick_drop = rr_pick(req, inc_id(id_q), 1'b0);
        pick_exp  = rr_pick(req, inc_id(id_q), 1'b1);
        case (state_q)
            IDLE: begin
                dwell_d = '0;
                if (pick_idle[IDW]) begin
                    state_d = SHOW;
                    id_d    = pick_idle[IDW-1:0];
                end
            end
            SHOW: begin
                if (PREEMPT && req[0] && id_q != '0) begin
                    id_d    = '0;
                    dwell_d = '0;
                end else if (!req[id_q]) begin
                    dwell_d = '0;
                    if (pick_drop[IDW])
                        id_d = pick_drop[IDW-1:0];
                    else
                        state_d = IDLE;
                end else if ((&dwell_q) && pick_exp[IDW]) begin
                    id_d = pick_exp[IDW-1:0];
                    rr_d = inc_id(pick_exp[IDW-1:0]);
                end
            end
            default: state_d = IDLE;
        endcase
        // value follows the grant that takes effect on this same edge
        if (state_d == SHOW)
            value_d = req_value[int'(id_d)*WIDTH +: WIDTH];
    end

    always_comb begin
        grant       = (state_q == SHOW) ? (NREQ'(1) << id_q) : '0;
        value_valid = (state_q == SHOW);
        active_id   = id_q;
        value_out   = value_q;
    end
endmodule

// File: tb/tb_segment_arbiter.sv
// tb/tb_segment_arbiter.sv - directed self-checking bench for segment_arbiter
module tb_segment_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [31:0]  rv [4];
    logic [127:0] req_value;
    logic [3:0]   grant;
    logic [1:0]   active_id;
    logic [31:0]  value_out;
    logic         value_valid;
    int           tests = 0;
    int           fails = 0;

    assign req_value = {rv[3], rv[2], rv[1], rv[0]};

    segment_arbiter #(.NREQ(4), .WIDTH(32), .DWELL_LOG2(3)) dut (
        .clk(clk), .rst(rst), .req(req), .req_value(req_value),
        .grant(grant), .active_id(active_id),
        .value_out(value_out), .value_valid(value_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        rv[0] = 32'h0000_00F0;
        rv[1] = 32'hAAAA_0001;
        rv[2] = 32'hBBBB_0002;
        rv[3] = 32'h3333_3333;

        // reset held with all requests pending
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_grant", grant, 4'b0000);
            chk("rst_value", value_out, 32'h0);
            chk("rst_valid", value_valid, 1'b0);
        end
        rst = 1'b0;
        tick();
        chk("first_grant", grant, 4'b0001);
        chk("first_id", active_id, 2'd0);
        chk("first_value", value_out, 32'h0000_00F0);
        chk("first_valid", value_valid, 1'b1);

        // two-way rotation with 8-cycle dwell
        req = 4'b0110;
        tick();
        chk("rot_id1_grant", grant, 4'b0010);
        chk("rot_id1_value", value_out, 32'hAAAA_0001);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rot_id1_hold", grant, 4'b0010);
        end
        tick();
        chk("rot_id2_grant", grant, 4'b0100);
        chk("rot_id2_value", value_out, 32'hBBBB_0002);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("rot_id2_hold", grant, 4'b0100);
        end
        tick();
        chk("rot_back_grant", grant, 4'b0010);
        chk("rot_back_value", value_out, 32'hAAAA_0001);

        // lone requester keeps grant across dwell wraps
        req = 4'b1000;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("solo_grant", grant, 4'b1000);
            chk("solo_valid", value_valid, 1'b1);
        end
        req = 4'b0000;
        tick();
        chk("idle_grant", grant, 4'b0000);
        chk("idle_valid", value_valid, 1'b0);
        chk("idle_value_hold", value_out, 32'h3333_3333);

        // drop mid-dwell hands over and restarts the dwell
        req = 4'b0010;
        tick();
        chk("drop_pre_grant", grant, 4'b0010);
        tick(); tick(); tick();
        req = 4'b0100;
        tick();
        chk("drop_handover", grant, 4'b0100);
        chk("drop_id", active_id, 2'd2);
        req = 4'b0110;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("drop_new_dwell", grant, 4'b0100);
        end
        tick();
        chk("drop_dwell_end", grant, 4'b0010);

        // live source tracked with one cycle of latency
        req = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            rv[1] = 32'h1000_0000 + 32'(i);
            tick();
            chk("live_value", value_out, 32'h1000_0000 + 32'(i));
        end

        // requester 0 arrives while id2 is two cycles into its dwell
        req = 4'b0100;
        tick();
        chk("pre_id2_grant", grant, 4'b0100);
        tick(); tick();
        req = 4'b0101;
`ifdef SEGARB_PREEMPT_EN
        tick();
        chk("preempt_grant", grant, 4'b0001);
        chk("preempt_value", value_out, 32'h0000_00F0);
`else
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nopreempt_hold", grant, 4'b0100);
        end
        tick();
        chk("nopreempt_next", grant, 4'b0001);
        chk("nopreempt_value", value_out, 32'h0000_00F0);
`endif

        // reset mid-dwell
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_grant", grant, 4'b0000);
        chk("midrst_value", value_out, 32'h0);
        chk("midrst_id", active_id, 2'd0);
        rst = 1'b0;
        req = 4'b0100;
        tick();
        chk("post_rst_grant", grant, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
